// File: rtl/controle_mult.sv
// Shift-add multiplier control: Moore FSM plus iteration counter driving ACC's Load/Ad/Sh strobes.
// Define CONTROLE_DEBUG_EN to expose the state code (Estado) and iteration count (Contagem).
module controle_mult #(
    parameter int unsigned N_BITS = 4
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic St,
    input  logic M,
    output logic Load,
    output logic Ad,
    output logic Sh,
    output logic Done
`ifdef CONTROLE_DEBUG_EN
    ,
    output logic [2:0]                 Estado,
    output logic [$clog2(N_BITS)-1:0]  Contagem
`endif
);

    localparam int unsigned CW = $clog2(N_BITS);
    localparam logic [CW-1:0] LAST = CW'(N_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CHECK = 3'd2,
        S_ADD   = 3'd3,
        S_SHIFT = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t        state;
    state_t        next;
    logic [CW-1:0] count;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next;
        end
    end

    // Counter restarts on every load and saturates at the last iteration.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            count <= '0;
        end else if (state == S_LOAD) begin
            count <= '0;
        end else if (state == S_SHIFT && count != LAST) begin
            count <= count + 1'b1;
        end
    end

    always_comb begin
        next = state;
        Load = 1'b0;
        Ad   = 1'b0;
        Sh   = 1'b0;
        Done = 1'b0;
        case (state)
            S_IDLE: begin
                if (St) next = S_LOAD;
            end
            S_LOAD: begin
                Load = 1'b1;
                next = S_CHECK;
            end
            S_CHECK: begin
                next = M ? S_ADD : S_SHIFT;
            end
            S_ADD: begin
                Ad   = 1'b1;
                next = S_SHIFT;
            end
            S_SHIFT: begin
                Sh   = 1'b1;
                next = (count == LAST) ? S_DONE : S_CHECK;
            end
            S_DONE: begin
                Done = 1'b1;
                if (!St) next = S_IDLE;
            end
            default: begin
                next = S_IDLE;
            end
        endcase
    end

`ifdef CONTROLE_DEBUG_EN
    assign Estado   = state;
    assign Contagem = count;
`endif

    a_strobes_onehot0: assert property (@(posedge Clk) disable iff (!Rst_n)
        $onehot0({Load, Ad, Sh, Done}));

    a_count_bounded: assert property (@(posedge Clk) disable iff (!Rst_n)
        count <= LAST);

endmodule
